// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - write, read and clear-control signals of the multi-read-port register file
interface reg_file_mp_if #(
  parameter int WordLength   = 8,
  parameter int AddrBits     = 3,
  parameter int NumReadPorts = 2
);
  logic                                       clear_i;
  logic                                       busy_o;
  logic                                       wr_en_i;
  logic [AddrBits-1:0]                        w_addr_i;
  logic [WordLength-1:0]                      w_data_i;
  logic [WordLength/8-1:0]                    w_be_i;
  logic [NumReadPorts-1:0][AddrBits-1:0]      r_addr_i;
  logic [NumReadPorts-1:0][WordLength-1:0]    r_data_o;

  modport master (
    output clear_i, wr_en_i, w_addr_i, w_data_i, w_be_i, r_addr_i,
    input  busy_o, r_data_o
  );

  modport slave (
    input  clear_i, wr_en_i, w_addr_i, w_data_i, w_be_i, r_addr_i,
    output busy_o, r_data_o
  );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - byte-enable register file, N read ports, clear sequencer
// Define REG_FILE_MP_ASYNC_READ_EN for combinational reads without bypass.
module reg_file_mp #(
  parameter int                    WordLength   = 8,
  parameter int                    AddrBits     = 3,
  parameter int                    NumReadPorts = 2,
  parameter logic [WordLength-1:0] ClearValue   = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  reg_file_mp_if.slave bus
);
  localparam int Depth    = 2**AddrBits;
  localparam int NumBytes = WordLength / 8;

  if ((WordLength % 8) != 0 || NumReadPorts < 1) begin : g_bad_params
    $error("reg_file_mp: WordLength must be a multiple of 8 and NumReadPorts >= 1");
  end

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                                  r_state, w_state_nxt;
  logic [AddrBits-1:0]                     r_clr_ptr, w_clr_ptr_nxt;
  logic [WordLength-1:0]                   r_mem [Depth];
  logic [WordLength-1:0]                   w_merged;
  logic                                    w_clr_wr, w_user_wr;
  logic [NumReadPorts-1:0][WordLength-1:0] w_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_INIT;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_clr_wr      = 1'b0;
    w_user_wr     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clr_wr = 1'b1;
        // Pointer parks on the last entry rather than wrapping.
        if (r_clr_ptr == AddrBits'(Depth - 1)) begin
          w_state_nxt = ST_READY;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
      end
      ST_READY: begin
        w_user_wr = bus.wr_en_i;
        if (bus.clear_i) begin
          w_state_nxt   = ST_INIT;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_INIT;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  assign bus.busy_o = (r_state == ST_INIT);

  // Old word with enabled lanes replaced; shared by the write path and the read bypass.
  always_comb begin
    w_merged = r_mem[bus.w_addr_i];
    for (int b = 0; b < NumBytes; b++) begin
      if (bus.w_be_i[b]) begin
        w_merged[8*b +: 8] = bus.w_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_clr_wr) begin
        r_mem[r_clr_ptr] <= ClearValue;
      end else if (w_user_wr) begin
        r_mem[bus.w_addr_i] <= w_merged;
      end
    end
  end

`ifdef REG_FILE_MP_ASYNC_READ_EN
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NumReadPorts; k++) begin
      w_rdata[k] = r_mem[bus.r_addr_i[k]];
    end
  end

  assign bus.r_data_o = w_rdata;
`else
  logic [NumReadPorts-1:0][WordLength-1:0] r_rdata;

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NumReadPorts; k++) begin
      if (r_state == ST_INIT) begin
        // Entries at or below the pointer are cleared, or being cleared this cycle.
        w_rdata[k] = (bus.r_addr_i[k] <= r_clr_ptr) ? ClearValue : r_mem[bus.r_addr_i[k]];
      end else if (bus.wr_en_i && (bus.r_addr_i[k] == bus.w_addr_i)) begin
        w_rdata[k] = w_merged;
      end else begin
        w_rdata[k] = r_mem[bus.r_addr_i[k]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign bus.r_data_o = r_rdata;
`endif
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp against an array reference model
module tb_reg_file_mp;
  localparam int          WL = 32;
  localparam int          AB = 3;
  localparam int          NP = 2;
  localparam int          DEPTH = 8;
  localparam logic [31:0] CV = 32'hA5A5_A5A5;

  typedef struct {
    int          due;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;

  reg_file_mp_if #(.WordLength(WL), .AddrBits(AB), .NumReadPorts(NP)) bus ();

  reg_file_mp #(
    .WordLength(WL), .AddrBits(AB), .NumReadPorts(NP), .ClearValue(CV)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  exp_t        sb_q[$];
  int          edge_cnt    = 0;
  int          vectors     = 0;
  int          miscompares = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_init = 1'b1;
  int          m_clr  = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic push(input int kind, input int port, input logic [31:0] exp);
    exp_t e;
    e.due = edge_cnt + 1; e.kind = kind; e.port = port; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick(input bit rst, input bit clr, input bit wr, input int waddr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input int ra0, input int ra1, input bit chk);
    int ra[NP];
    ra[0] = ra0; ra[1] = ra1;
    rst_i        = rst;
    bus.clear_i  = clr;
    bus.wr_en_i  = wr;
    bus.w_addr_i = AB'(waddr);
    bus.w_data_i = wdata;
    bus.w_be_i   = be;
    for (int k = 0; k < NP; k++) bus.r_addr_i[k] = AB'(ra[k]);

    for (int k = 0; k < NP; k++) begin
      if (rst) push(1, k, 32'h0);
      else if (chk && !m_init && !clr)
        push(1, k, (wr && ra[k] == waddr) ? merge(m_mem[waddr], wdata, be) : m_mem[ra[k]]);
    end

    if (rst) begin
      m_init = 1'b1; m_clr = 0;
    end else if (m_init) begin
      m_mem[m_clr] = CV;
      if (m_clr == DEPTH - 1) m_init = 1'b0;
      else m_clr++;
    end else begin
      if (wr) m_mem[waddr] = merge(m_mem[waddr], wdata, be);
      if (clr) begin m_init = 1'b1; m_clr = 0; end
    end
    push(0, 0, {31'b0, m_init});

    @(posedge clk_i);
    edge_cnt++;
    #1;
  endtask

  task automatic idle(input int ra0, input int ra1, input bit chk);
    tick(0, 0, 0, 0, 32'h0, 4'h0, ra0, ra1, chk);
  endtask

  task automatic write(input int a, input logic [31:0] d, input logic [3:0] be,
                       input int ra0, input int ra1);
    tick(0, 0, 1, a, d, be, ra0, ra1, 1);
  endtask

  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk_i) begin
    while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
      mon_e   = sb_q.pop_front();
      mon_act = (mon_e.kind == 0) ? {31'b0, bus.busy_o} : bus.r_data_o[mon_e.port];
      vectors++;
      if (mon_act !== mon_e.exp) begin
        miscompares++;
        $display("FAIL %s port=%0d edge=%0d actual=%h expected=%h",
                 (mon_e.kind == 0) ? "busy_o" : "r_data_o", mon_e.port, mon_e.due,
                 mon_act, mon_e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog edge=%0d actual=timeout expected=finish", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; bus.clear_i = 1'b0; bus.wr_en_i = 1'b0;
    bus.w_addr_i = '0; bus.w_data_i = '0; bus.w_be_i = '0; bus.r_addr_i = '0;

    // Reset, then the power-on clear with an ignored write to entry 0.
    tick(1, 0, 0, 0, 32'h0, 4'h0, 0, 0, 1);
    tick(1, 0, 0, 0, 32'h0, 4'h0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 2) tick(0, 0, 1, 0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      else idle(0, 0, 0);
    end
    for (int a = 0; a < DEPTH; a++) idle(a, DEPTH - 1 - a, 1);

    // Byte-enable merge on entry 2.
    write(2, 32'h1122_3344, 4'hF, 0, 1);
    write(2, 32'hAABB_CCDD, 4'b0101, 3, 3);
    idle(2, 2, 1);

    // Write-first bypass on port 0, neighbour on port 1.
    write(5, 32'h0, 4'hF, 4, 4);
    write(5, 32'h0000_003C, 4'hF, 5, 4);
    idle(5, 4, 1);
    write(6, 32'h1234_5678, 4'h0, 6, 6);

    // Runtime clear, with a second request during busy.
    for (int a = 0; a < DEPTH; a++) write(a, 32'h5A5A_5A5A, 4'hF, a, a);
    tick(0, 1, 0, 0, 32'h0, 4'h0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) tick(0, (i == 3), 0, 0, 32'h0, 4'h0, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) idle(a, a, 1);

    // Reset in the middle of a clear.
    for (int a = 0; a < DEPTH; a++) write(a, 32'h0F0F_0F0F, 4'hF, 0, 0);
    tick(0, 1, 0, 0, 32'h0, 4'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) idle(0, 0, 0);
    tick(1, 0, 0, 0, 32'h0, 4'h0, 3, 6, 1);
    for (int i = 0; i < DEPTH; i++) idle(0, 0, 0);
    for (int a = 0; a < DEPTH; a++) idle(a, DEPTH - 1 - a, 1);

    // Randomised traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 150) == 0, ($urandom % 40) == 0, $urandom % 2,
           $urandom_range(0, DEPTH - 1), $urandom, 4'($urandom),
           $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1);
    end

    idle(0, 0, 0);
    idle(0, 0, 0);
    @(negedge clk_i);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port register file. One synchronous write port with byte enables and N independent read ports. Reads are registered, with write-first bypass. A built-in clear sequencer fills the whole array with a programmable value after reset or on request. Used as the storage core for multi-consumer FIFOs and descriptor tables in fifo_ip.

Parameters:
WordLength, 8, data word width in bits; must be a multiple of 8
AddrBits, 3, address width; depth = 2**AddrBits
NumReadPorts, 2, number of independent read ports (>=1)
ClearValue, '0, value written to every entry by the clear sequencer

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous active-high reset
clear_i  input  1  request a full-array clear (pulse; sampled only in READY)
busy_o  output  1  1 while the clear sequencer is running
wr_en_i  input  1  write enable
w_addr_i  input  AddrBits  write address
w_data_i  input  WordLength  write data
w_be_i  input  WordLength/8  byte enables; bit b enables w_data_i[8b+7:8b]
r_addr_i  input  NumReadPorts x AddrBits  packed read addresses, port k at [k]
r_data_o  output  NumReadPorts x WordLength  packed read data, port k at [k]

Behaviour:
- Reset: rst_i is synchronous and active-high on clk_i. During a reset cycle: FSM -> INIT, clear pointer -> 0, r_data_o -> all 0, busy_o -> 1. Array contents are not touched by reset itself.
- FSM states: INIT, READY.
  - INIT: each cycle, write ClearValue to entry clr_ptr and increment clr_ptr. When clr_ptr == 2**AddrBits-1, that entry is written and the next state is READY. Clear takes exactly 2**AddrBits cycles after rst_i deasserts.
  - READY: if clear_i==1, next state is INIT with clr_ptr=0. A user write in that same cycle is still performed, then overwritten by the clear.
- busy_o = 1 in INIT and during reset, 0 in READY. Registered from state; no combinational path from clear_i.
- In INIT, wr_en_i is ignored (no write, no error). clear_i is ignored in INIT; there is no restart of the pointer.
- Write (READY only): on a rising edge with wr_en_i=1, each byte lane b with w_be_i[b]=1 is updated. Lanes with w_be_i[b]=0 keep their old value. wr_en_i=1 with w_be_i=0 is a no-op.
- Read: latency 1. r_data_o[k] at edge t+1 reflects r_addr_i[k] sampled at edge t.
- Read-during-write (READY): if r_addr_i[k]==w_addr_i with wr_en_i=1, r_data_o[k] returns the merged word (new bytes where w_be_i=1, old bytes elsewhere). This is write-first.
- Read in INIT: r_data_o[k] returns ClearValue if the entry has already been cleared or is being cleared this cycle. Otherwise it returns the stored content. The bench checks reads only when busy_o=0.
- Multiple ports may read the same address in the same cycle; all return identical data.
- Addresses wrap naturally at 2**AddrBits. The clear pointer stops at its last value and does not wrap.
- Elaboration: assertion fails if WordLength%8 != 0 or NumReadPorts < 1.

Optional Feature:
Macro: REG_FILE_MP_ASYNC_READ_EN.
- Defined: read ports are combinational. r_data_o[k] = array[r_addr_i[k]] in the same cycle (latency 0), with no bypass. A write becomes visible after the clock edge, and the reset value of r_data_o is whatever the array holds.
- Undefined (default): registered read with write-first bypass, as above.
- Clear sequencer, byte enables and busy_o are identical in both builds.

Test Plan:
1. Clear after reset: ClearValue=8'hA5, AddrBits=3. Deassert rst_i -> busy_o=1 for exactly 8 cycles, then 0. Reads of addresses 0..7 on both ports -> 8'hA5.
2. Byte-enable write: WordLength=32, write 32'h11223344 with be=4'hF to addr 2, then 32'hAABBCCDD with be=4'b0101 -> read addr 2 returns 32'h11BB33DD one cycle after the address is applied.
3. Write-first bypass: entry 5 = 8'h00. Same cycle: write 8'h3C to addr 5 and read port 0 at addr 5 -> r_data_o[0]=8'h3C next cycle. Port 1 reading addr 4 is unaffected.
4. Ignored writes in INIT: assert wr_en_i to addr 0 with 8'hFF during busy_o=1 -> after busy_o falls, addr 0 = ClearValue.
5. Runtime clear: fill all entries with 8'h5A, pulse clear_i -> busy_o rises next cycle, stays 1 for 8 cycles. All entries read ClearValue afterwards. A clear_i pulse issued during busy_o=1 does not extend busy.
6. Reset mid-clear: assert rst_i at clear cycle 4 -> r_data_o=0 and busy_o=1 next cycle. The full 8-cycle clear restarts from addr 0 after release.
